// File: rtl/apb_i2cs_ram_pkg.sv
// Shared types for the parametrised mailbox RAM: clear engine states and
// read-during-write policy encodings.
package apb_i2cs_ram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    localparam bit RDW_NEW_DATA = 1'b1;
    localparam bit RDW_OLD_DATA = 1'b0;

endpackage

// File: rtl/apb_i2cs_ram_array.sv
// Raw simple-dual-port storage: masked synchronous write, read-first synchronous
// read port, no reset. Kept minimal so a technology macro can drop in.
module apb_i2cs_ram_array #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_mask,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // A read colliding with a write returns the pre-write word; the top
    // level applies the bypass merge when new data is wanted.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= (mem[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/apb_i2cs_ram_sdp.sv
// Parametrised simple-dual-port RAM with hardware clear engine, per-bit write
// mask, range checking, read-during-write bypass and optional output register.
module apb_i2cs_ram_sdp
    import apb_i2cs_ram_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH     = 8,
    parameter int unsigned           ADDR_WIDTH     = 8,
    parameter int unsigned           DEPTH          = 2 ** ADDR_WIDTH,
    parameter bit                    OUT_REG        = 1'b0,
    parameter bit                    BYPASS         = RDW_NEW_DATA,
    parameter bit                    CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [DATA_WIDTH-1:0] wr_mask_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    input  logic                  clear_i,
    output logic                  busy_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
    localparam clr_state_e            RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  clearing_c;

    // Clear engine state and address counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clearing_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (clear_i) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                clearing_c = 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
        endcase
    end

    assign busy_o = (state_q == ST_CLEAR);

    // User access qualification: nothing gets through while clearing.
    logic wr_in_range_c, rd_in_range_c, wr_acc_c, rd_acc_c;

    assign wr_in_range_c = (32'(wr_addr_i) < DEPTH);
    assign rd_in_range_c = (32'(rd_addr_i) < DEPTH);
    assign wr_acc_c      = wr_en_i && !busy_o && wr_in_range_c;
    assign rd_acc_c      = rd_en_i && !busy_o;

    logic                  arr_we_c, arr_re_c;
    logic [ADDR_WIDTH-1:0] arr_waddr_c;
    logic [DATA_WIDTH-1:0] arr_wdata_c, arr_wmask_c, arr_rdata;

    assign arr_we_c    = clearing_c || wr_acc_c;
    assign arr_waddr_c = clearing_c ? cnt_q : wr_addr_i;
    assign arr_wdata_c = clearing_c ? CLEAR_VALUE : wr_data_i;
    assign arr_wmask_c = clearing_c ? {DATA_WIDTH{1'b1}} : wr_mask_i;
    assign arr_re_c    = rd_acc_c && rd_in_range_c;

    apb_i2cs_ram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk     (clk_i),
        .wr_en   (arr_we_c),
        .wr_addr (arr_waddr_c),
        .wr_data (arr_wdata_c),
        .wr_mask (arr_wmask_c),
        .rd_en   (arr_re_c),
        .rd_addr (rd_addr_i),
        .rd_data (arr_rdata)
    );

    // First read stage: valid, in-range flag and colliding write captured
    // alongside the array read so the merge can be formed afterwards.
    logic                  v0_q, have_q, byp_q;
    logic [DATA_WIDTH-1:0] byp_data_q, byp_mask_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v0_q       <= 1'b0;
            have_q     <= 1'b0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
            byp_mask_q <= '0;
        end else begin
            v0_q <= rd_acc_c;
            if (rd_acc_c) begin
                have_q     <= rd_in_range_c;
                byp_q      <= (BYPASS == RDW_NEW_DATA) && wr_acc_c && (wr_addr_i == rd_addr_i);
                byp_data_q <= wr_data_i;
                byp_mask_q <= wr_mask_i;
            end
        end
    end

    // Array output is undefined until the first in-range read, so it is
    // masked to zero until then and for out-of-range reads.
    logic [DATA_WIDTH-1:0] d0_c;

    always_comb begin
        d0_c = '0;
        if (have_q) begin
            d0_c = byp_q ? ((arr_rdata & ~byp_mask_q) | (byp_data_q & byp_mask_q))
                         : arr_rdata;
        end
    end

    if (OUT_REG) begin : g_out_reg
        logic [DATA_WIDTH-1:0] data_q;
        logic                  valid_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= v0_q;
                if (v0_q) begin
                    data_q <= d0_c;
                end
            end
        end

        assign rd_data_o  = data_q;
        assign rd_valid_o = valid_q;
    end else begin : g_no_out_reg
        assign rd_data_o  = d0_c;
        assign rd_valid_o = v0_q;
    end

endmodule

// File: doc/apb_i2cs_ram_sdp.md
# apb_i2cs_ram_sdp

Parametrised simple-dual-port synchronous RAM for the I2C slave mailbox path and other APB peripherals. Generalises the fixed 256x8 mailbox RAM. Adds:
- configurable width and depth;
- per-bit write mask;
- optional output register and read-valid tracking;
- defined read-during-write policy;
- a hardware clear engine that initialises the array after reset or on request.

Single clock domain; storage stays in a swappable array sub-module so a technology macro can replace it.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per word (1..64)
- ADDR_WIDTH, 8, address bits
- DEPTH, 2**ADDR_WIDTH, number of words (2..2**ADDR_WIDTH)
- OUT_REG, 0, 1 adds an output register stage
- BYPASS, 1, 1 = read-during-write to the same address returns new data; 0 = old data
- CLEAR_ON_RESET, 1, 1 = clear engine runs automatically after reset
- CLEAR_VALUE, '0, word written by the clear engine

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset. One clock; reset is asynchronous and active-low.
- wr_en_i  in  1  write request
- wr_addr_i  in  ADDR_WIDTH  write address
- wr_data_i  in  DATA_WIDTH  write data
- wr_mask_i  in  DATA_WIDTH  per-bit write enable (1 = update bit)
- rd_en_i  in  1  read request
- rd_addr_i  in  ADDR_WIDTH  read address
- rd_data_o  out  DATA_WIDTH  read data
- rd_valid_o  out  1  rd_data_o holds data for an accepted read
- clear_i  in  1  start clear (level, sampled in IDLE)
- busy_o  out  1  clear in progress; user accesses ignored

## Operation
- **Clear FSM states: IDLE, CLEAR.**
  - Reset enters CLEAR if CLEAR_ON_RESET=1, else IDLE.
  - IDLE -> CLEAR when clear_i=1.
  - CLEAR -> IDLE after the counter writes DEPTH-1.
- **Clear counter.**
  - Counter is ADDR_WIDTH bits, starts at 0 and increments by 1 per cycle.
  - Each cycle in CLEAR writes CLEAR_VALUE to all bits of the counter's address.
- **busy_o.** busy_o = (state == CLEAR).
  - While busy_o=1, wr_en_i and rd_en_i are ignored: no write, no rd_valid_o.
  - clear_i while already in CLEAR is ignored; the clear does not restart.
- **Writes.** When accepted, mem[wr_addr_i] = (mem & ~wr_mask_i) | (wr_data_i & wr_mask_i).
- **Reads.** An accepted read registers rd_addr_i; data appears per the Timing section.
- **Out of range (addr >= DEPTH).**
  - Writes are dropped.
  - Reads complete with rd_valid_o=1 and data 0.
- **Same-address read and write in the same cycle:**
  - BYPASS=1: returned data is the merged new word.
  - BYPASS=0: returned data is the pre-write word.
- **Reads accepted in the cycle before CLEAR starts** complete normally and return pre-clear data.
- **Memory contents** are not reset by rst_ni; only the clear engine initialises them.

## Timing
- **Write:** committed at the clk_i edge where it is accepted; visible to a read accepted on the next edge.
- **Read latency, OUT_REG=0:**
  - Read accepted at edge N; rd_data_o and rd_valid_o are valid after edge N.
  - rd_valid_o is high for exactly one cycle per read.
- **Read latency, OUT_REG=1:** valid after edge N+1. Back-to-back reads give one result per cycle.
- **rd_data_o:** holds its last value when rd_valid_o=0.
- **Clear duration:** after reset release (or the edge sampling clear_i), edges 1..DEPTH write addresses 0..DEPTH-1.
  - busy_o falls after edge DEPTH.
  - The first user access is accepted on edge DEPTH+1.
- **Reset values:**
  - rd_data_o = 0, rd_valid_o = 0.
  - busy_o = CLEAR_ON_RESET; clear counter = 0.
  - Output pipeline registers = 0.
- **Reset asserted mid-clear or mid-read:**
  - In-flight reads are discarded; rd_valid_o=0 immediately.
  - The clear restarts from address 0 on release if CLEAR_ON_RESET=1.

## Structure
- Package apb_i2cs_ram_pkg holds:
  - the clear FSM state typedef (IDLE, CLEAR);
  - the BYPASS policy localparams (RDW_NEW_DATA=1, RDW_OLD_DATA=0).
- Sub-module apb_i2cs_ram_array holds the raw storage:
  - synchronous masked write;
  - registered read address;
  - no reset;
  - replaceable by a macro.
- Top level owns the clear FSM and counter, write muxing (clear vs user), range check, bypass compare, output register and valid pipeline.

## Test plan
- **Reset clear:** DEPTH=16, CLEAR_VALUE=8'hA5, release reset.
  - busy_o stays high for exactly 16 cycles.
  - Reads of addresses 0..15 then return 8'hA5.
- **Masked write:**
  - Write 8'hFF to address 3, then data 8'h00 with mask 8'h0F.
  - Read address 3 -> 8'hF0 with rd_valid_o one cycle after accept (OUT_REG=0), two cycles after (OUT_REG=1).
- **Collision:** address 7 holds 8'h11; write 8'h22 to address 7 and read address 7 in the same cycle.
  - BYPASS=1 returns 8'h22.
  - BYPASS=0 returns 8'h11.
  - A following read returns 8'h22 in both cases.
- **Out of range:** DEPTH=12, write 8'h5A to address 13, read address 13 -> 8'h00 with rd_valid_o=1; addresses 0..11 unchanged.
- **Mid-operation events:**
  - Pulse clear_i during a 4-deep back-to-back read burst: reads accepted before busy_o complete with old data; rd_en_i during busy_o yields no rd_valid_o.
  - Assert rst_ni low at clear address 5: clear restarts from 0; rd_valid_o=0 immediately.
